// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MD_SIGNED_EN to build signed mult/div; otherwise they act as multu/divu.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, w_busy_nxt;
  logic [31:0]   r_hold_hi, r_hold_lo, w_hold_hi_nxt, w_hold_lo_nxt;
  logic [31:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;

  // Divider sees a nonzero divisor; the B==0 result is substituted separately.
  logic [31:0] w_bsafe;
  logic [63:0] w_uprod;
  logic [31:0] w_uquo, w_urem;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_bsafe = (B == '0) ? 32'd1 : B;
  assign w_uprod = {32'd0, A} * {32'd0, B};
  assign w_uquo  = A / w_bsafe;
  assign w_urem  = A % w_bsafe;

`ifdef MD_SIGNED_EN
  logic [63:0] w_sprod;
  logic [31:0] w_amag, w_bmag, w_qmag, w_rmag, w_squo, w_srem;

  assign w_sprod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_amag  = A[31] ? -A : A;
  assign w_bmag  = w_bsafe[31] ? -w_bsafe : w_bsafe;
  assign w_qmag  = w_amag / w_bmag;
  assign w_rmag  = w_amag % w_bmag;
  // Magnitude divide then re-sign; 0x80000000 / -1 wraps back to 0x80000000.
  assign w_squo  = (A[31] ^ B[31]) ? -w_qmag : w_qmag;
  assign w_srem  = A[31] ? -w_rmag : w_rmag;
`endif

  always_comb begin
    w_res_hi = w_uprod[63:32];
    w_res_lo = w_uprod[31:0];
    if (MDOp[1]) begin
      if (B == '0) begin
        w_res_hi = A;
        w_res_lo = '1;
      end else begin
        w_res_hi = w_urem;
        w_res_lo = w_uquo;
`ifdef MD_SIGNED_EN
        if (MDOp[0]) begin
          w_res_hi = w_srem;
          w_res_lo = w_squo;
        end
`endif
      end
    end else begin
`ifdef MD_SIGNED_EN
      if (MDOp[0]) begin
        w_res_hi = w_sprod[63:32];
        w_res_lo = w_sprod[31:0];
      end
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_hold_hi_nxt = r_hold_hi;
    w_hold_lo_nxt = r_hold_lo;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    case (r_state)
      IDLE: begin
        if (Start) begin
          if (!MDOp[2]) begin
            w_hold_hi_nxt = w_res_hi;
            w_hold_lo_nxt = w_res_lo;
            w_cnt_nxt     = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            w_busy_nxt    = 1'b1;
            w_state_nxt   = BUSY;
          end else if (!MDOp[1]) begin
            if (MDOp[0]) w_lo_nxt = A;
            else         w_hi_nxt = A;
          end
        end
      end
      BUSY: begin
        if (r_cnt == CW'(1)) begin
          w_hi_nxt    = r_hold_hi;
          w_lo_nxt    = r_hold_lo;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_hold_hi <= '0;
      r_hold_lo <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_hold_hi <= w_hold_hi_nxt;
      r_hold_lo <= w_hold_lo_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
    end
  end

  assign Busy = r_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized ops against
// an arithmetic reference model of HI/LO and Busy timing.
module tb_md_unit;

`ifdef MD_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  MDOp = '0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'(a) * 64'(b);
    if (op == 3'd1 && SGN) begin
      p = 64'(sa * sb);
    end else if (op[1]) begin
      if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
      else if (op[0] && SGN) begin
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end else p = {a % b, a / b};
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic busy_exp);
    check({tag, ".busy"}, {31'd0, Busy}, {31'd0, busy_exp});
    check({tag, ".hi"}, HI, m_hi);
    check({tag, ".lo"}, LO, m_lo);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // inj: -1 none, 0..7 fixed op driven with inj_a while busy, 8 random
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int inj, input logic [31:0] inj_a);
    logic [63:0] res;
    int unsigned n;
    res = model(op, a, b);
    n = op[1] ? DC : MC;
    Start = 1'b1; MDOp = op; A = a; B = b;
    tick;
    Start = 1'b0; A = $urandom; B = $urandom;
    check_state("md.accept", 1'b1);
    for (int unsigned k = 1; k <= n; k++) begin
      if (inj >= 0) begin
        Start = 1'b1;
        MDOp = (inj == 8) ? 3'($urandom_range(0, 7)) : 3'(inj);
        A = (inj == 8) ? $urandom : inj_a;
        B = $urandom;
      end
      tick;
      Start = 1'b0;
      if (k < n) check_state("md.inflight", 1'b1);
      else begin
        m_hi = res[63:32];
        m_lo = res[31:0];
        check_state("md.commit", 1'b0);
      end
    end
  endtask

  task automatic do_mv(input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1; MDOp = op; A = a; B = $urandom;
    tick;
    Start = 1'b0;
    if (op == 3'd4) m_hi = a;
    else if (op == 3'd5) m_lo = a;
    check_state("mv", 1'b0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] ra, rb;

    repeat (2) tick;
    check_state("reset", 1'b0);
    reset = 1'b0;
    tick;
    check_state("post_reset", 1'b0);

    do_md(3'd1, 32'hFFFF_FFFE, 32'd3, -1, '0);
    check("mult_m2x3.hi", HI, SGN ? 32'hFFFF_FFFF : 32'd2);
    check("mult_m2x3.lo", LO, 32'hFFFF_FFFA);

    do_md(3'd2, 32'd100, 32'd7, -1, '0);
    check("divu_100_7.lo", LO, 32'd14);
    check("divu_100_7.hi", HI, 32'd2);

    do_md(3'd3, 32'hFFFF_FFF9, 32'd2, -1, '0);
    check("div_m7_2.lo", LO, SGN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
    check("div_m7_2.hi", HI, SGN ? 32'hFFFF_FFFF : 32'd1);

    do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1, '0);
    check("div_ovf.lo", LO, SGN ? 32'h8000_0000 : 32'd0);
    check("div_ovf.hi", HI, SGN ? 32'd0 : 32'h8000_0000);

    do_md(3'd2, 32'd5, 32'd0, -1, '0);
    check("divu_by0.lo", LO, 32'hFFFF_FFFF);
    check("divu_by0.hi", HI, 32'd5);
    do_md(3'd3, 32'hFFFF_FFF0, 32'd0, -1, '0);
    check("div_by0.hi", HI, 32'hFFFF_FFF0);

    do_mv(3'd4, 32'h1234_5678);
    do_mv(3'd5, 32'hCAFE_BABE);
    check("mthi.hi", HI, 32'h1234_5678);
    check("mtlo.lo", LO, 32'hCAFE_BABE);
    do_mv(3'd6, 32'hDEAD_BEEF);
    do_mv(3'd7, 32'hDEAD_BEEF);

    do_md(3'd0, 32'd3, 32'd4, 5, 32'd9);
    check("multu_inj.hi", HI, 32'd0);
    check("multu_inj.lo", LO, 32'd12);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 15) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      if (!op[2]) do_md(op, ra, rb, ($urandom_range(0, 3) == 0) ? 8 : -1, '0);
      else do_mv(op, ra);
    end

    do_mv(3'd4, 32'hA5A5_0001);
    do_mv(3'd5, 32'h5A5A_0002);
    Start = 1'b1; MDOp = 3'd0; A = 32'd7; B = 32'd9;
    tick;
    Start = 1'b0;
    check_state("rst_mid.accept", 1'b1);
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    check_state("rst_mid.async", 1'b0);
    #2 reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      check_state("rst_mid.no_commit", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
